// File: rtl/cpu_qsys_dct_pkg.sv
// cpu_qsys_dct_pkg: shared DCT packing constants and the drain FSM state type.
package cpu_qsys_dct_pkg;
    localparam int DCT_FRAG_W = 3;
    localparam int DCT_SLOTS  = 10;
    localparam int DCT_BUF_W  = DCT_FRAG_W * DCT_SLOTS;
    typedef enum logic [1:0] {RUN, DRAIN, ENDED} dct_state_t;
endpackage

// File: rtl/cpu_qsys_dct_out_reg.sv
// cpu_qsys_dct_out_reg: output holding register; the word stays stable while valid is high and ready is low.
module cpu_qsys_dct_out_reg #(
    parameter int BUF_W = 30,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buf,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             out_ready,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             out_valid,
    output logic             out_free
);
    assign out_free = !out_valid || out_ready;
    // load is only raised by the packer when out_free is already true
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            out_valid  <= 1'b0;
        end else if (load) begin
            dct_buffer <= load_buf;
            dct_count  <= load_cnt;
            out_valid  <= 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: rtl/cpu_qsys_dct_pack_ctrl.sv
// cpu_qsys_dct_pack_ctrl: packs trace fragments into DCT words, flushes partial words
// and runs the end-of-test drain that raises test_has_ended.
module cpu_qsys_dct_pack_ctrl
    import cpu_qsys_dct_pkg::*;
#(
    parameter int FRAG_W = DCT_FRAG_W,
    parameter int SLOTS  = DCT_SLOTS,
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 16,
    localparam int BUF_W = FRAG_W * SLOTS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frag_valid,
    input  logic [FRAG_W-1:0] frag_data,
    output logic              frag_ready,
    input  logic              flush_req,
    input  logic              test_ending,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              test_has_ended,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);
    dct_state_t       state, state_nx;
    logic [BUF_W-1:0] asm_buf;
    logic [CNT_W-1:0] asm_cnt;
    logic             flush_pend, out_free, promote, accept;
    assign frag_ready     = (state == RUN) && (asm_cnt < FULL) && !flush_pend;
    assign accept         = frag_valid && frag_ready;
    assign promote        = out_free && (asm_cnt == FULL ||
                            ((flush_pend || state == DRAIN) && asm_cnt != '0));
    assign test_has_ended = state == ENDED;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            asm_buf    <= '0;
            asm_cnt    <= '0;
            flush_pend <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (promote) begin
                asm_buf    <= '0;
                asm_cnt    <= '0;
                flush_pend <= 1'b0;
                frame_cnt  <= frame_cnt + FCNT_W'(1);
            end else begin
                // cleared slots are zero, so OR-ing the shifted fragment places it
                if (accept) begin
                    asm_buf <= asm_buf | (BUF_W'(frag_data) << (FRAG_W * int'(asm_cnt)));
                    asm_cnt <= asm_cnt + CNT_W'(1);
                end
                if (flush_req && asm_cnt != '0 && state != ENDED)
                    flush_pend <= 1'b1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = test_ending ? DRAIN : RUN;
            DRAIN:   state_nx = (asm_cnt == '0 && !out_valid) ? ENDED : DRAIN;
            default: state_nx = state;
        endcase
    end
    cpu_qsys_dct_out_reg #(.BUF_W(BUF_W), .CNT_W(CNT_W)) u_out (
        .clk        (clk),
        .reset      (reset),
        .load       (promote),
        .load_buf   (asm_buf),
        .load_cnt   (asm_cnt),
        .out_ready  (out_ready),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .out_valid  (out_valid),
        .out_free   (out_free)
    );
endmodule

// File: tb/tb_cpu_qsys_dct_pack_ctrl.sv
// tb_cpu_qsys_dct_pack_ctrl: directed bench with a word scoreboard for the DCT pack controller.
module tb_cpu_qsys_dct_pack_ctrl;
    logic        clk = 0, reset = 1, frag_valid = 0, flush_req = 0, test_ending = 0, out_ready = 1;
    logic [2:0]  frag_data = '0;
    logic        frag_ready, out_valid, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frame_cnt;
    int          n_assert = 0, n_fail = 0;
    logic [33:0] sb[$];
    logic [33:0] sb_e;
    logic [29:0] mbuf = '0;
    int          mcnt = 0;

    always #5 clk = ~clk;

    cpu_qsys_dct_pack_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .frag_valid     (frag_valid),
        .frag_data      (frag_data),
        .frag_ready     (frag_ready),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .test_has_ended (test_has_ended),
        .frame_cnt      (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push();
        if (mcnt != 0) sb.push_back({mbuf, 4'(mcnt)});
        mbuf = '0;
        mcnt = 0;
    endtask

    task automatic model_frag(input logic [2:0] f);
        mbuf |= 30'(f) << (3 * mcnt);
        mcnt++;
        if (mcnt == 10) model_push();
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [2:0] f);
        int b = 0;
        frag_valid = 1;
        frag_data  = f;
        while (!frag_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("frag_accept_wait", 32'(b < 100), 1);
        @(negedge clk);
        frag_valid = 0;
        model_frag(f);
    endtask

    // sampled after the bench's negedge drives settle, i.e. the values the next posedge sees
    always @(negedge clk) begin
        #1;
        if (!reset && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                sb_e = sb.pop_front();
                check("sb_buf", 32'(dct_buffer), 32'(sb_e[33:4]));
                check("sb_cnt", 32'(dct_count), 32'(sb_e[3:0]));
            end
        end
    end

    initial begin
        int b;
        @(negedge clk);
        @(negedge clk);
        check("rst_buf", 32'(dct_buffer), 0);
        check("rst_cnt", 32'(dct_count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ended", 32'(test_has_ended), 0);
        check("rst_frame", 32'(frame_cnt), 0);
        reset = 0;

        // full word
        for (int i = 0; i < 10; i++) send(3'b101);
        check("t1_valid_early", 32'(out_valid), 0);
        check("t1_ready_full", 32'(frag_ready), 0);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_buf", 32'(dct_buffer), 32'h2DB6DB6D);
        check("t1_cnt", 32'(dct_count), 10);
        check("t1_frame", 32'(frame_cnt), 1);

        // partial flush
        send(3'd1); send(3'd2); send(3'd3);
        flush_req = 1;
        @(negedge clk);
        flush_req = 0;
        model_push();
        check("t2_pend", 32'(dut.flush_pend), 1);
        check("t2_ready_low", 32'(frag_ready), 0);
        check("t2_valid_early", 32'(out_valid), 0);
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 1);
        check("t2_buf", 32'(dct_buffer), 32'h0D1);
        check("t2_cnt", 32'(dct_count), 3);
        check("t2_asm_cnt", 32'(dut.asm_cnt), 0);
        check("t2_ready_back", 32'(frag_ready), 1);
        check("t2_frame", 32'(frame_cnt), 2);
        @(negedge clk);
        check("t2_drained", 32'(out_valid), 0);

        // backpressure
        out_ready = 0;
        for (int i = 0; i < 20; i++) send(3'b001);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_buf", 32'(dct_buffer), 32'h09249249);
            check("t3_hold_cnt", 32'(dct_count), 10);
            check("t3_ready_low", 32'(frag_ready), 0);
            check("t3_hold_frame", 32'(frame_cnt), 3);
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        check("t3_b2b_valid", 32'(out_valid), 1);
        check("t3_b2b_buf", 32'(dct_buffer), 32'h09249249);
        check("t3_b2b_frame", 32'(frame_cnt), 4);
        @(negedge clk);
        check("t3_done", 32'(out_valid), 0);

        // end of test with a partial word
        send(3'd7); send(3'd6); send(3'd5); send(3'd4);
        test_ending = 1;
        @(negedge clk);
        test_ending = 0;
        model_push();
        check("t4_drain_ready", 32'(frag_ready), 0);
        check("t4_valid_early", 32'(out_valid), 0);
        @(negedge clk);
        check("t4_valid", 32'(out_valid), 1);
        check("t4_cnt", 32'(dct_count), 4);
        check("t4_buf", 32'(dct_buffer), 32'h977);
        @(negedge clk);
        check("t4_accepted", 32'(out_valid), 0);
        check("t4_not_ended", 32'(test_has_ended), 0);
        @(negedge clk);
        check("t4_ended", 32'(test_has_ended), 1);
        frag_valid = 1;
        frag_data  = 3'd3;
        flush_req  = 1;
        test_ending = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_ready_ended", 32'(frag_ready), 0);
        end
        frag_valid = 0;
        flush_req  = 0;
        test_ending = 0;
        check("t4_asm_cnt", 32'(dut.asm_cnt), 0);
        check("t4_sticky", 32'(test_has_ended), 1);
        check("t4_frame", 32'(frame_cnt), 5);
        check("t4_no_word", 32'(out_valid), 0);

        // empty flush, then end
        reset = 1;
        @(negedge clk);
        check("t5_rst_ended", 32'(test_has_ended), 0);
        check("t5_rst_frame", 32'(frame_cnt), 0);
        reset = 0;
        flush_req = 1;
        @(negedge clk);
        flush_req = 0;
        check("t5_no_pend", 32'(dut.flush_pend), 0);
        check("t5_no_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("t5_no_valid2", 32'(out_valid), 0);
        test_ending = 1;
        @(negedge clk);
        test_ending = 0;
        b = 0;
        while (!test_has_ended && b < 2) begin
            @(negedge clk);
            b++;
        end
        check("t5_ended", 32'(test_has_ended), 1);
        check("t5_frame", 32'(frame_cnt), 0);

        // reset mid-word
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 5; i++) send(3'd7);
        reset = 1;
        @(negedge clk);
        reset = 0;
        mbuf = '0;
        mcnt = 0;
        check("t6_asm_cnt", 32'(dut.asm_cnt), 0);
        check("t6_asm_buf", 32'(dut.asm_buf), 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_buf", 32'(dct_buffer), 0);
        check("t6_cnt", 32'(dct_count), 0);
        check("t6_frame", 32'(frame_cnt), 0);
        for (int i = 0; i < 10; i++) send(3'd2);
        @(negedge clk);
        check("t6_word_valid", 32'(out_valid), 1);
        check("t6_word_cnt", 32'(dct_count), 10);
        check("t6_word_buf", 32'(dct_buffer), 32'h12492492);
        check("t6_word_frame", 32'(frame_cnt), 1);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
